// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU.
//   CPU4_PC_W / CPU4_INSTR_W : default address and instruction widths
//   OP_JMP / OP_JZ / OP_HLT  : opcodes that are not plain sequential
//   fsm_state_t              : fetch controller state encoding (3-bit)
package cpu4_pkg;

  localparam int CPU4_PC_W    = 4;
  localparam int CPU4_INSTR_W = 8;

  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    SELECT = 3'd3,
    UPDATE = 3'd4,
    HALT   = 3'd5
  } fsm_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// PC-mux link between the fetch controller (master) and the PC mux (slave).
//   nextPC   : sequential successor PC        (master -> slave)
//   branchPC : jump target                    (master -> slave)
//   Jump     : selects branchPC over nextPC   (master -> slave)
//   pc_in    : the mux's registered result    (slave  -> master)
// Handshake: there is no valid/ready pair on this link. The master holds
// nextPC/branchPC/Jump stable from DECODE through UPDATE; the slave registers
// its selection during SELECT, and the master samples pc_in in UPDATE.
interface pc_fetch_ctrl_if
  import cpu4_pkg::*;
#(
  parameter int PC_W = CPU4_PC_W
);

  logic [PC_W-1:0] nextPC;
  logic [PC_W-1:0] branchPC;
  logic            Jump;
  logic [PC_W-1:0] pc_in;

  modport master (output nextPC, output branchPC, output Jump, input pc_in);
  modport slave  (input nextPC, input branchPC, input Jump, output pc_in);

endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch/sequencing controller for the 4-bit CPU.
// Holds the architectural PC, fetches from a combinational ROM, drives the
// PC mux and adopts the mux's registered result as the new PC.
// Ports:
//   clock, reset      : rising-edge clock, async active-high reset
//   run               : level; starts execution from IDLE
//   zero_flag         : ALU zero flag, consulted by JZ in DECODE
//   instr_addr        : ROM address, always equal to pc
//   instr_data        : ROM data (combinational from instr_addr)
//   pcmux             : PC-mux link (master side)
//   ir                : latched instruction
//   ir_valid          : one-cycle strobe, ir has retired to execute. No
//                       backpressure: execute must take it in that cycle.
//   halted            : high once HLT has been decoded
//   retired           : saturating count of completed instructions
//   dbg_state         : current FSM state
module pc_fetch_ctrl
  import cpu4_pkg::*;
#(
  parameter int              PC_W     = CPU4_PC_W,
  parameter int              INSTR_W  = CPU4_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               zero_flag,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  pc_fetch_ctrl_if.master    pcmux,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic               halted,
  output logic [7:0]         retired,
  output fsm_state_t         dbg_state
);

  fsm_state_t      state;
  fsm_state_t      state_nxt;
  logic [PC_W-1:0] pc;
  logic [3:0]      op;

  assign op         = ir[INSTR_W-1 -: 4];
  assign instr_addr = pc;
  assign dbg_state  = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // run only matters in IDLE; once an instruction starts it always completes
  // and the loop returns to FETCH without looking at run again.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = FETCH;
      FETCH:   state_nxt = DECODE;
      DECODE:  state_nxt = SELECT;
      SELECT:  state_nxt = UPDATE;
      UPDATE:  state_nxt = (op == OP_HLT) ? HALT : FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc             <= RESET_PC;
      ir             <= '0;
      pcmux.nextPC   <= '0;
      pcmux.branchPC <= '0;
      pcmux.Jump     <= 1'b0;
      ir_valid       <= 1'b0;
      halted         <= 1'b0;
      retired        <= '0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        FETCH: ir <= instr_data;
        DECODE: begin
          // pc + 1 is truncated to PC_W, so the top address wraps to 0
          pcmux.nextPC   <= pc + PC_W'(1);
          pcmux.branchPC <= ir[PC_W-1:0];
          pcmux.Jump     <= (op == OP_JMP) || ((op == OP_JZ) && zero_flag);
        end
        UPDATE: begin
          pcmux.Jump <= 1'b0;
          if (op == OP_HLT) begin
            halted <= 1'b1;
          end else begin
            pc       <= pcmux.pc_in;
            ir_valid <= 1'b1;
            if (retired != 8'hFF) retired <= retired + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;
  import cpu4_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic       run = 1'b0;
  logic       run2 = 1'b0;
  logic       zero_flag = 1'b0;
  logic [7:0] rom [16];

  logic [3:0] instr_addr, instr_addr2;
  logic [7:0] instr_data, instr_data2, ir, ir2, retired, retired2;
  logic       ir_valid, ir_valid2, halted, halted2;
  fsm_state_t st, st2;

  pc_fetch_ctrl_if bus ();
  pc_fetch_ctrl_if bus2 ();

  assign instr_data  = rom[instr_addr];
  assign instr_data2 = rom[instr_addr2];

  pc_fetch_ctrl dut (
    .clock(clock), .reset(reset), .run(run), .zero_flag(zero_flag),
    .instr_addr(instr_addr), .instr_data(instr_data), .pcmux(bus),
    .ir(ir), .ir_valid(ir_valid), .halted(halted), .retired(retired),
    .dbg_state(st)
  );

  pc_fetch_ctrl #(.RESET_PC(4'd15)) dut2 (
    .clock(clock), .reset(reset), .run(run2), .zero_flag(zero_flag),
    .instr_addr(instr_addr2), .instr_data(instr_data2), .pcmux(bus2),
    .ir(ir2), .ir_valid(ir_valid2), .halted(halted2), .retired(retired2),
    .dbg_state(st2)
  );

  // PC mux models: registered select of branchPC/nextPC
  always_ff @(posedge clock or posedge reset) begin
    if (reset) bus.pc_in <= '0;
    else       bus.pc_in <= bus.Jump ? bus.branchPC : bus.nextPC;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) bus2.pc_in <= '0;
    else       bus2.pc_in <= bus2.Jump ? bus2.branchPC : bus2.nextPC;
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] obs_pc[$];
  int         obs_cyc[$];
  logic       exp_jmp[$];
  logic       obs_jmp[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
  endtask

  // called right after tick(), so the pulse sits clear of both clock edges
  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    exp_q.delete(); obs_pc.delete(); obs_cyc.delete();
    exp_jmp.delete(); obs_jmp.delete();
  endtask

  // records the pc at every ir_valid pulse and Jump as seen in SELECT
  task automatic run_cycles(input int n, input bit stop_on_halt);
    for (int c = 0; c < n; c++) begin
      if (stop_on_halt && halted) break;
      tick();
      if (ir_valid) begin
        obs_pc.push_back(instr_addr);
        obs_cyc.push_back(c);
      end
      if (st == SELECT) obs_jmp.push_back(bus.Jump);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({instr_addr, ir, ir_valid, halted, retired, bus.nextPC, bus.branchPC, bus.Jump} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0h ir=%0h v=%0b h=%0b ret=%0d n=%0h b=%0h j=%0b expected all zero",
               instr_addr, ir, ir_valid, halted, retired, bus.nextPC, bus.branchPC, bus.Jump);
    end
    checks++;
    if (st !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", st, IDLE); end
    checks++;
    if (instr_addr2 !== 4'd15) begin errors++; $display("FAIL reset_pc_param: got %0h expected f", instr_addr2); end
    #1;
    reset = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (st !== IDLE) begin errors++; $display("FAIL idle_hold: got %0d expected %0d", st, IDLE); end
  endtask

  task automatic test_sequential();
    logic [3:0] e, o;
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h20; rom[2] = 8'hF0;
    tick(); do_reset();
    exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    exp_jmp.push_back(1'b0); exp_jmp.push_back(1'b0); exp_jmp.push_back(1'b0);
    run = 1'b1;
    run_cycles(100, 1'b1);
    run = 1'b0;
    checks++;
    if (obs_cyc.size() != 2 || obs_cyc[1] - obs_cyc[0] != 4) begin
      errors++;
      $display("FAIL seq_spacing: got %0d pulses expected 2 pulses 4 cycles apart", obs_cyc.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_pc.size() == 0) begin errors++; $display("FAIL seq_pc: got no pulse expected pc=%0h", e); end
      else begin
        o = obs_pc.pop_front();
        if (o !== e) begin errors++; $display("FAIL seq_pc: got %0h expected %0h", o, e); end
      end
    end
    checks++;
    if (obs_jmp.size() != exp_jmp.size() || obs_jmp != exp_jmp) begin
      errors++; $display("FAIL seq_jump: got %p expected %p", obs_jmp, exp_jmp);
    end
    checks++;
    if (halted !== 1'b1 || instr_addr !== 4'd2 || retired !== 8'd2) begin
      errors++;
      $display("FAIL seq_halt: got h=%0b pc=%0h ret=%0d expected h=1 pc=2 ret=2", halted, instr_addr, retired);
    end
    run = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    run = 1'b0;
    checks++;
    if (st !== HALT || instr_addr !== 4'd2) begin
      errors++; $display("FAIL halt_sticky: got st=%0d pc=%0h expected st=%0d pc=2", st, instr_addr, HALT);
    end
  endtask

  task automatic test_jump();
    clear_rom();
    rom[0] = 8'hE5; rom[5] = 8'hF0;
    tick(); do_reset();
    run = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.Jump !== 1'b1 || bus.branchPC !== 4'd5 || bus.nextPC !== 4'd1) begin
      errors++;
      $display("FAIL jmp_decode: got j=%0b b=%0h n=%0h expected j=1 b=5 n=1", bus.Jump, bus.branchPC, bus.nextPC);
    end
    tick();
    checks++;
    if (st !== UPDATE || bus.pc_in !== 4'd5) begin
      errors++; $display("FAIL jmp_mux: got st=%0d pc_in=%0h expected st=%0d pc_in=5", st, bus.pc_in, UPDATE);
    end
    tick();
    checks++;
    if (instr_addr !== 4'd5 || ir_valid !== 1'b1 || bus.Jump !== 1'b0) begin
      errors++;
      $display("FAIL jmp_update: got pc=%0h v=%0b j=%0b expected pc=5 v=1 j=0", instr_addr, ir_valid, bus.Jump);
    end
    run_cycles(40, 1'b1);
    run = 1'b0;
    checks++;
    if (halted !== 1'b1 || instr_addr !== 4'd5 || retired !== 8'd1) begin
      errors++;
      $display("FAIL jmp_halt: got h=%0b pc=%0h ret=%0d expected h=1 pc=5 ret=1", halted, instr_addr, retired);
    end
  endtask

  task automatic test_cond_jump(input logic z);
    logic [3:0] e, o;
    clear_rom();
    rom[0] = 8'hE3; rom[3] = 8'hD9;
    tick(); do_reset();
    zero_flag = z;
    exp_q.push_back(4'd3); exp_q.push_back(z ? 4'd9 : 4'd4);
    exp_jmp.push_back(1'b1); exp_jmp.push_back(z); exp_jmp.push_back(1'b0);
    run = 1'b1;
    run_cycles(100, 1'b1);
    run = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_pc.size() == 0) begin errors++; $display("FAIL jz%0b_pc: got no pulse expected pc=%0h", z, e); end
      else begin
        o = obs_pc.pop_front();
        if (o !== e) begin errors++; $display("FAIL jz%0b_pc: got %0h expected %0h", z, o, e); end
      end
    end
    checks++;
    if (obs_jmp.size() != exp_jmp.size() || obs_jmp != exp_jmp) begin
      errors++; $display("FAIL jz%0b_jump: got %p expected %p", z, obs_jmp, exp_jmp);
    end
    checks++;
    if (halted !== 1'b1 || instr_addr !== (z ? 4'd9 : 4'd4) || retired !== 8'd2) begin
      errors++;
      $display("FAIL jz%0b_halt: got h=%0b pc=%0h ret=%0d expected h=1 pc=%0h ret=2",
               z, halted, instr_addr, retired, z ? 4'd9 : 4'd4);
    end
    zero_flag = 1'b0;
  endtask

  task automatic test_wrap();
    int budget;
    clear_rom();
    rom[15] = 8'h10; rom[0] = 8'hF0;
    tick(); do_reset();
    run2 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus2.nextPC !== 4'd0 || bus2.Jump !== 1'b0) begin
      errors++; $display("FAIL wrap_next: got n=%0h j=%0b expected n=0 j=0", bus2.nextPC, bus2.Jump);
    end
    tick(); tick();
    checks++;
    if (instr_addr2 !== 4'd0 || ir_valid2 !== 1'b1 || retired2 !== 8'd1) begin
      errors++;
      $display("FAIL wrap_pc: got pc=%0h v=%0b ret=%0d expected pc=0 v=1 ret=1", instr_addr2, ir_valid2, retired2);
    end
    budget = 20;
    while (!halted2 && budget > 0) begin tick(); budget--; end
    run2 = 1'b0;
    checks++;
    if (halted2 !== 1'b1 || instr_addr2 !== 4'd0 || retired2 !== 8'd1) begin
      errors++;
      $display("FAIL wrap_halt: got h=%0b pc=%0h ret=%0d expected h=1 pc=0 ret=1", halted2, instr_addr2, retired2);
    end
  endtask

  task automatic test_async_reset();
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h20;
    tick(); do_reset();
    run = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (st !== SELECT || instr_addr !== 4'd1 || bus.nextPC !== 4'd2) begin
      errors++;
      $display("FAIL ar_setup: got st=%0d pc=%0h n=%0h expected st=%0d pc=1 n=2", st, instr_addr, bus.nextPC, SELECT);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({instr_addr, ir, ir_valid, halted, retired, bus.nextPC, bus.branchPC, bus.Jump} !== '0 || st !== IDLE) begin
      errors++;
      $display("FAIL ar_abort: got st=%0d pc=%0h ir=%0h ret=%0d n=%0h expected IDLE and all zero",
               st, instr_addr, ir, retired, bus.nextPC);
    end
    run = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (st !== IDLE || instr_addr !== 4'd0) begin
      errors++; $display("FAIL ar_idle: got st=%0d pc=%0h expected st=%0d pc=0", st, instr_addr, IDLE);
    end
  endtask

  task automatic test_saturation();
    clear_rom();
    rom[0] = 8'hE0;
    tick(); do_reset();
    run = 1'b1;
    // 3 cycles to the first UPDATE, then one retirement every 4 cycles
    run_cycles(3 + 4 * 300, 1'b0);
    run = 1'b0;
    checks++;
    if (obs_pc.size() != 300) begin
      errors++; $display("FAIL sat_pulses: got %0d expected 300", obs_pc.size());
    end
    checks++;
    if (retired !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d expected 255", retired); end
    checks++;
    if (instr_addr !== 4'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL sat_loop: got pc=%0h h=%0b expected pc=0 h=0", instr_addr, halted);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_rom();
    test_reset();
    test_sequential();
    test_jump();
    test_cond_jump(1'b1);
    test_cond_jump(1'b0);
    test_wrap();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch/sequencing controller for the 4-bit CPU; it is the producer end of the PC-mux interface.
- Holds the architectural PC and fetches the 8-bit instruction from combinational instruction ROM.
- Drives nextPC / branchPC / Jump into the PC mux, then captures the mux's registered nextnextPC as the new PC.
- Hands the fetched instruction to the execute stage with a one-cycle valid strobe.

Parameters:
- PC_W, 4, program-counter and address width.
- INSTR_W, 8, instruction width; [7:4] opcode, [3:0] operand/target.
- RESET_PC, 0, PC value after reset.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; leaves IDLE when sampled high.
- zero_flag  input  1  ALU zero flag, used by JZ; sampled in DECODE.
- instr_addr  output  PC_W  ROM address (= pc).
- instr_data  input  INSTR_W  ROM data, combinational from instr_addr.
- nextPC  output  PC_W  sequential successor to the PC mux.
- branchPC  output  PC_W  jump target to the PC mux.
- Jump  output  1  branch select to the PC mux.
- pc_in  input  PC_W  registered output of the PC mux (its nextnextPC).
- ir  output  INSTR_W  latched instruction.
- ir_valid  output  1  one-cycle strobe, ir ready for execute.
- halted  output  1  high in HALT state.
- retired  output  8  count of completed instructions, saturating.

Behaviour:
- Reset (asynchronous, active-high) sets every register:
  - state=IDLE, pc=RESET_PC, ir=0.
  - nextPC=0, branchPC=0, Jump=0, ir_valid=0, halted=0, retired=0.
- Reset mid-instruction aborts immediately with the same values.
- Opcodes (package constants): JMP=4'hE, JZ=4'hD, HLT=4'hF. All other opcodes are sequential.
- instr_addr = pc combinationally, in all states.
- FSM, one transition per rising clock edge:
  - IDLE: if run=1, go to FETCH; otherwise stay.
  - FETCH: ir <= instr_data; go to DECODE.
  - DECODE:
    - Register nextPC <= pc+1, modulo 2^PC_W, so 15 wraps to 0.
    - Register branchPC <= ir[3:0].
    - Register Jump <= (op==JMP) | (op==JZ & zero_flag).
    - Go to SELECT. These outputs are valid from the edge leaving DECODE.
  - SELECT: wait one cycle while the PC mux registers its output. Go to UPDATE.
  - UPDATE:
    - If op==HLT: go to HALT; pc is unchanged.
    - Otherwise: pc <= pc_in; ir_valid=1 for this cycle only; retired <= retired+1, saturating at 255; go to FETCH.
    - Jump returns to 0 on the edge leaving UPDATE.
  - HALT: halted=1; outputs hold. Leaves HALT only on reset; run is ignored here.
- Throughput: 4 cycles per instruction (FETCH, DECODE, SELECT, UPDATE).
- run dropping mid-instruction has no effect; the current instruction completes. The FSM re-enters FETCH regardless of run.
- JZ with zero_flag=0 behaves as sequential: Jump=0.
- JMP to its own address loops indefinitely; this is legal.
- HLT is not counted in retired and does not pulse ir_valid.
- pc_in is trusted; no consistency check against the expected value.

Decomposition:
- Shared package cpu4_pkg holds:
  - PC_W and INSTR_W defaults.
  - Opcode constants OP_JMP, OP_JZ, OP_HLT.
  - The FSM state encoding: IDLE, FETCH, DECODE, SELECT, UPDATE, HALT, 3-bit.
- No sub-module inside this block.
- The bench instantiates pc_fetch_ctrl together with the existing PCMux. Connections: nextPC/branchPC/Jump go to the mux inputs; the mux's nextnextPC goes to pc_in.

Test Plan:
- Sequential run: ROM[0..2]=8'h10,8'h20,8'hF0, run=1 -> pc steps 0→1→2. ir_valid pulses twice, 4 cycles apart. halted=1 with pc=2, retired=2.
- Unconditional jump: ROM[0]=8'hE5, ROM[5]=8'hF0 -> branchPC=5, Jump=1 after DECODE. pc=5 at UPDATE, then HALT with pc=5.
- Conditional jump: ROM[3]=8'hD9 at pc=3. With zero_flag=1: Jump=1, pc→9. With zero_flag=0: Jump=0, pc→4.
- Wrap-around: RESET_PC=15, ROM[15]=8'h10 -> nextPC=0, pc wraps to 0.
- Async reset mid-instruction: assert reset during SELECT, between clock edges. All outputs go to reset values immediately. After release with run=0, the FSM stays IDLE and pc=0.
- Saturation: JMP-to-self loop for 300 instructions -> retired stops at 255; ir_valid keeps pulsing.
